// File: rtl/reg_file_pkg.sv
// Shared pipeline types and constants for the integer register file.
package reg_file_pkg;

  localparam int NUM_REGS = 32;
  localparam int XLEN     = 32;
  localparam int REG_ZERO = 0;

  typedef logic [$clog2(NUM_REGS)-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]             word_t;

endpackage

// File: rtl/reg_file_hot_bit.sv
// One-hot index decoder: sets exactly one bit of hot_o, selected by idx_i.
module Hot_Bit #(
  parameter  int DEPTH = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [IDX_W-1:0] idx_i,
  output logic [DEPTH-1:0] hot_o
);

  // NOTE: assign every always_comb output first so no path leaves it unassigned (no latch).
  always_comb begin
    hot_o        = '0;
    hot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/reg_file.sv
// RISC-V integer register file: x0 hardwired to zero, one write port,
// two combinational read ports with write-first bypass.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int DEPTH  = NUM_REGS,
  parameter  int WIDTH  = XLEN,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2
);

  localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(REG_ZERO);

  logic [DEPTH-1:0] hot;
  logic [WIDTH-1:0] entry [DEPTH];
  logic             unused_hot0;

  Hot_Bit #(.DEPTH(DEPTH)) u_hot_bit (
    .idx_i (waddr),
    .hot_o (hot)
  );

  // x0 has no storage, so its decoder line goes nowhere.
  assign unused_hot0 = hot[0];
  assign entry[0]    = '0;

  for (genvar i = 1; i < DEPTH; i++) begin : g_entry
    logic             load;
    logic [WIDTH-1:0] data_q;

    assign load = we & hot[i];

    // NOTE: sequential state uses non-blocking assignments; reset is synchronous and
    // clears every entry, taking priority over a write in the same cycle.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q <= '0;
      end else if (load) begin
        data_q <= wdata;
      end
    end

    assign entry[i] = data_q;
  end

  // Read path is not gated by rst: a write-back in a reset cycle still bypasses.
  always_comb begin
    rdata1 = entry[raddr1];
    if (we && (waddr == raddr1)) rdata1 = wdata;
    if (raddr1 == IDX_ZERO)      rdata1 = '0;
  end

  always_comb begin
    rdata2 = entry[raddr2];
    if (we && (waddr == raddr2)) rdata2 = wdata;
    if (raddr2 == IDX_ZERO)      rdata2 = '0;
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file (default 32 x 32 configuration).
module tb_reg_file;
  import reg_file_pkg::*;

  logic     clk;
  logic     rst;
  logic     we;
  reg_idx_t waddr;
  word_t    wdata;
  reg_idx_t raddr1;
  reg_idx_t raddr2;
  word_t    rdata1;
  word_t    rdata2;

  int checks = 0;
  int errors = 0;

  reg_file dut (
    .clk    (clk),
    .rst    (rst),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    raddr1 = '0; raddr2 = '0;
    tick();
    rst = 1'b0; we = 1'b0;

    // Reset: every entry reads zero, including the one written during reset.
    for (int i = 0; i < 32; i++) begin
      raddr1 = reg_idx_t'(i);
      raddr2 = reg_idx_t'(31 - i);
      #1;
      check("reset_r1", rdata1, '0);
      check("reset_r2", rdata2, '0);
    end
    raddr1 = 5'd5; raddr2 = 5'd5; #1;
    check("reset_x5", rdata1, '0);

    // Write then read.
    we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
    tick();
    we = 1'b0; raddr1 = 5'd7; raddr2 = 5'd6; #1;
    check("wr_x7", rdata1, 32'h1234_5678);
    check("wr_x6", rdata2, '0);

    // x0 immutability, same cycle and next cycle.
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; raddr1 = 5'd0; raddr2 = 5'd0; #1;
    check("x0_same", rdata1, '0);
    check("x0_same_r2", rdata2, '0);
    tick();
    we = 1'b0; #1;
    check("x0_next", rdata1, '0);

    // Bypass with both ports on the same entry.
    we = 1'b1; waddr = 5'd3; wdata = 32'hA;
    tick();
    wdata = 32'hB; raddr1 = 5'd3; raddr2 = 5'd3; #1;
    check("byp_r1", rdata1, 32'hB);
    check("byp_r2", rdata2, 32'hB);
    tick();
    we = 1'b0; #1;
    check("byp_after_r1", rdata1, 32'hB);
    check("byp_after_r2", rdata2, 32'hB);

    // No bypass when we is low.
    we = 1'b1; wdata = 32'hA;
    tick();
    we = 1'b0; wdata = 32'hB; #1;
    check("nobyp_r1", rdata1, 32'hA);
    check("nobyp_r2", rdata2, 32'hA);

    // One-hot isolation: x(i) = i.
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; waddr = reg_idx_t'(i); wdata = word_t'(i);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = reg_idx_t'(i);
      raddr2 = reg_idx_t'(31 - i);
      #1;
      check("iso_r1", rdata1, word_t'(i));
      check("iso_r2", rdata2, word_t'(31 - i));
    end

    // Reset mid-stream.
    we = 1'b1; waddr = 5'd9; wdata = 32'h55;
    tick();
    rst = 1'b1; we = 1'b0;
    tick();
    rst = 1'b0; raddr1 = 5'd9; raddr2 = 5'd7; #1;
    check("mid_rst_x9", rdata1, '0);
    check("mid_rst_x7", rdata2, '0);
    we = 1'b1; waddr = 5'd9; wdata = 32'h66;
    tick();
    we = 1'b0; #1;
    check("post_rst_x9", rdata1, 32'h66);

    // Bypass stays live during reset, but the write is discarded.
    rst = 1'b1; we = 1'b1; waddr = 5'd4; wdata = 32'h77; raddr1 = 5'd4; #1;
    check("rst_byp", rdata1, 32'h77);
    tick();
    rst = 1'b0; we = 1'b0; #1;
    check("rst_discard", rdata1, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
